// File: rtl/usart_pkg.sv
// usart_pkg: frame constants, shared TX/RX state type and parity helper.
// Build option: define USART_ODD_PARITY_EN for odd parity (default is even).
`default_nettype none

package usart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } usart_state_e;

    // Parity bit value sent on the line for a given data byte.
    function automatic logic usart_parity(input logic [DATA_BITS-1:0] d);
`ifdef USART_ODD_PARITY_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/usart_loopback_core_if.sv
// usart_loopback_core_if: serial lines, transmit byte, receiver clear and receive results.
// Rev 1.0 - initial release.
`default_nettype none

interface usart_loopback_core_if;
    import usart_pkg::*;

    logic [DATA_BITS-1:0] Data_Tx;
    logic                 Rx;
    logic                 CLR_Rec;
    logic                 Tx;
    logic                 CLK_B;
    logic [DATA_BITS-1:0] Data_Rx;
    logic                 parity_err;

    modport master (
        output Data_Tx, Rx, CLR_Rec,
        input  Tx, CLK_B, Data_Rx, parity_err
    );

    modport slave (
        input  Data_Tx, Rx, CLR_Rec,
        output Tx, CLK_B, Data_Rx, parity_err
    );

endinterface

`default_nettype wire

// File: rtl/usart_rx.sv
// usart_rx: 2-flop Rx synchronizer, mid-bit sampling receive FSM and result registers.
// Rev 1.0 - initial release. Parity sense follows USART_ODD_PARITY_EN via usart_pkg.
`default_nettype none

module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_clr_rec,
    input  wire logic                 i_rx,
    output logic [DATA_BITS-1:0]      o_data,
    output logic                      o_perr
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  c_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  c_HALF_M = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     c_LASTBIT = 3'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    usart_state_e         r_state,   w_state_nxt;
    logic [CW-1:0]        r_cnt,     w_cnt_nxt;
    logic [2:0]           r_idx,     w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 r_par_bit, w_par_bit_nxt;
    logic [DATA_BITS-1:0] r_data,    w_data_nxt;
    logic                 r_perr,    w_perr_nxt;
    logic                 w_rx;
    logic                 w_fall;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_data    <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_data    <= w_data_nxt;
            r_perr    <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_par_bit_nxt = r_par_bit;
        w_data_nxt    = r_data;
        w_perr_nxt    = r_perr;
        if (i_clr_rec) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_data_nxt  = '0;
            w_perr_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end
                end
                START: begin
                    // Half a bit after the edge: a high line means it was only a glitch.
                    if (r_cnt == c_HALF_M) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = w_rx ? IDLE : DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_LASTBIT) w_state_nxt = PARITY;
                        else                    w_idx_nxt   = r_idx + 3'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt     = '0;
                        w_par_bit_nxt = w_rx;
                        w_state_nxt   = STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        // A low stop bit is a framing error: results stay untouched.
                        if (w_rx == STOP_LEVEL) begin
                            w_data_nxt = r_shift;
                            w_perr_nxt = (usart_parity(r_shift) != r_par_bit);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_data = r_data;
    assign o_perr = r_perr;

endmodule

`default_nettype wire

// File: rtl/usart_loopback_core.sv
// usart_loopback_core: baud generator, free-running framed transmitter and usart_rx receiver.
// Rev 1.0 - initial release. Build option USART_ODD_PARITY_EN selects odd parity.
`default_nettype none

module usart_loopback_core
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic                  CLK,
    input  wire logic                  CLR,
    usart_loopback_core_if.slave       bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_HALF    = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]    c_LASTBIT = 3'(DATA_BITS - 1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [CW-1:0]        r_baud_cnt;
    logic                 w_tick;
    usart_state_e         r_tx_state, w_tx_state_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [2:0]           r_tx_idx,   w_tx_idx_nxt;
    logic                 r_tx_par,   w_tx_par_nxt;
    logic                 r_tx,       w_tx_nxt;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tick = (r_baud_cnt == c_LAST);

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_baud_cnt <= '0;
            r_tx_state <= IDLE;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= IDLE_LEVEL;
        end else begin
            r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_par_nxt   = r_tx_par;
        w_tx_nxt       = IDLE_LEVEL;
        if (w_tick) begin
            case (r_tx_state)
                IDLE: begin
                    w_tx_state_nxt = START;
                    w_tx_shift_nxt = bus.Data_Tx;
                    w_tx_par_nxt   = usart_parity(bus.Data_Tx);
                end
                START: begin
                    w_tx_state_nxt = DATA;
                    w_tx_idx_nxt   = '0;
                end
                DATA: begin
                    if (r_tx_idx == c_LASTBIT) begin
                        w_tx_state_nxt = PARITY;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 3'd1;
                        w_tx_shift_nxt = r_tx_shift >> 1;
                    end
                end
                PARITY:  w_tx_state_nxt = STOP;
                STOP:    w_tx_state_nxt = IDLE;
                default: w_tx_state_nxt = IDLE;
            endcase
        end
        // Line level is derived from the state being entered so Tx stays aligned to the tick.
        case (w_tx_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_tx_shift_nxt[0];
            PARITY:  w_tx_nxt = w_tx_par_nxt;
            STOP:    w_tx_nxt = STOP_LEVEL;
            default: w_tx_nxt = IDLE_LEVEL;
        endcase
    end

    assign bus.Tx    = r_tx;
    assign bus.CLK_B = (r_baud_cnt >= c_HALF);

    usart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (CLK),
        .rst_n     (w_rst_n),
        .i_clr_rec (bus.CLR_Rec),
        .i_rx      (bus.Rx),
        .o_data    (bus.Data_Rx),
        .o_perr    (bus.parity_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_usart_loopback_core.sv
// tb_usart_loopback_core: scoreboard bench; loopback phases then bench-driven random Rx frames.
`default_nettype none

module tb_usart_loopback_core;

    localparam int N     = 16;
    localparam int FRAME = 12 * N;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic r_loop = 1'b1;
    logic r_brx  = 1'b1;

    always #5 clk = ~clk;

    usart_loopback_core_if u_if ();
    assign u_if.Rx = r_loop ? u_if.Tx : r_brx;

    usart_loopback_core #(.CLKS_PER_BIT(N)) dut (
        .CLK (clk),
        .CLR (clr_n),
        .bus (u_if)
    );

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  sb_q[$];
    logic [8:0]  mon_last = '0;
    logic [8:0]  mon_cur;
    logic [8:0]  mon_exp;
    bit          mon_en = 1'b0;

    // Reference: parity bit as the count of ones modulo two.
    function automatic logic model_par(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
`ifdef USART_ODD_PARITY_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    // Reference line sequence from the start bit to the stop bit, index 0 sent first.
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        logic [10:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        b[9]  = model_par(d);
        b[10] = 1'b1;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = {u_if.Data_Rx, u_if.parity_err};
            if (mon_cur !== mon_last) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no change from 0x%0h", mon_cur, mon_last);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("rx_out", 32'(mon_cur), 32'(mon_exp));
                end
                mon_last = mon_cur;
            end
        end
    end

    task automatic wait_sb(input int max_cycles, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending results expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Waits for Tx to go low, then samples the middle of each of the 11 frame bits.
    task automatic tx_frame(input bit chg, input logic [7:0] nd, output logic [10:0] bits, output int lat);
        lat  = 0;
        bits = '1;
        while (u_if.Tx !== 1'b0 && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        if (u_if.Tx !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL tx_start_timeout: got Tx=%b expected start bit 0", u_if.Tx);
            return;
        end
        repeat (N / 2) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bits[i] = u_if.Tx;
            if (chg && i == 3) u_if.Data_Tx = nd;
            if (i < 10) repeat (N) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pbad, input bit fe);
        r_brx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            r_brx = d[i];
            repeat (N) @(negedge clk);
        end
        r_brx = model_par(d) ^ pbad;
        repeat (N) @(negedge clk);
        r_brx = fe ? 1'b0 : 1'b1;
        repeat (N) @(negedge clk);
        r_brx = 1'b1;
        repeat (N) @(negedge clk);
    endtask

    task automatic measure_clkb();
        int n, hi, lo;
        n = 0;
        while (u_if.CLK_B !== 1'b0 && n < 2 * N) begin @(negedge clk); n++; end
        n = 0;
        while (u_if.CLK_B !== 1'b1 && n < 2 * N) begin @(negedge clk); n++; end
        hi = 0;
        while (u_if.CLK_B === 1'b1 && hi < 2 * N) begin @(negedge clk); hi++; end
        lo = 0;
        while (u_if.CLK_B !== 1'b1 && lo < 2 * N) begin @(negedge clk); lo++; end
        check("clkb_high", 32'(hi), 32'(N / 2));
        check("clkb_period", 32'(hi + lo), 32'(N));
    endtask

    initial begin
        logic [10:0] bits;
        int          lat;
        logic [8:0]  last_vis;
        logic [7:0]  d;
        bit          pb, fe;

        u_if.Data_Tx = 8'h09;
        u_if.CLR_Rec = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(u_if.Tx), 32'd1);
        check("reset_clkb", 32'(u_if.CLK_B), 32'd0);
        check("reset_data_rx", 32'(u_if.Data_Rx), 32'h00);
        check("reset_perr", 32'(u_if.parity_err), 32'd0);
        mon_en = 1'b1;

        // Loopback, with Data_Tx switched in the middle of the first frame.
        sb_q.push_back({8'h09, 1'b0});
        sb_q.push_back({8'hF0, 1'b0});
        clr_n = 1'b1;
        tx_frame(1'b1, 8'hF0, bits, lat);
        check_range("first_start_latency", lat, N + 1, N + 3);
        check("tx_bits_09", 32'(bits), 32'(model_bits(8'h09)));
        tx_frame(1'b0, 8'h00, bits, lat);
        check("tx_bits_f0", 32'(bits), 32'(model_bits(8'hF0)));
        wait_sb(3 * FRAME, "loop_09_f0_timeout");
        measure_clkb();

        // Reset in the middle of a frame.
        repeat (3 * N) @(negedge clk);
        sb_q.push_back({8'h00, 1'b0});
        clr_n = 1'b0;
        #1;
        check("midreset_tx", 32'(u_if.Tx), 32'd1);
        check("midreset_clkb", 32'(u_if.CLK_B), 32'd0);
        check("midreset_data_rx", 32'(u_if.Data_Rx), 32'h00);
        check("midreset_perr", 32'(u_if.parity_err), 32'd0);
        repeat (3) @(negedge clk);
        sb_q.push_back({8'hF0, 1'b0});
        clr_n = 1'b1;
        tx_frame(1'b0, 8'h00, bits, lat);
        check_range("restart_latency", lat, N + 1, N + 3);
        check("tx_bits_after_reset", 32'(bits), 32'(model_bits(8'hF0)));
        wait_sb(3 * FRAME, "after_reset_timeout");

        // Receiver clear while the transmitter keeps running.
        sb_q.push_back({8'h00, 1'b0});
        u_if.CLR_Rec = 1'b1;
        u_if.Data_Tx = 8'h5A;
        tx_frame(1'b0, 8'h00, bits, lat);
        check("tx_during_clr_rec", 32'(bits), 32'(model_bits(8'h5A)));
        check("clr_rec_data_rx", 32'(u_if.Data_Rx), 32'h00);
        check("clr_rec_perr", 32'(u_if.parity_err), 32'd0);
        sb_q.push_back({8'h5A, 1'b0});
        u_if.CLR_Rec = 1'b0;
        wait_sb(2 * FRAME + 8, "clr_rec_recover_timeout");

        // Bench-driven receive line.
        r_brx  = 1'b1;
        r_loop = 1'b0;
        repeat (N) @(negedge clk);
        sb_q.push_back({8'hA5, 1'b1});
        send_frame(8'hA5, 1'b1, 1'b0);
        sb_q.push_back({8'h3C, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("frame_err_data_rx", 32'(u_if.Data_Rx), 32'h3C);
        check("frame_err_perr", 32'(u_if.parity_err), 32'd0);
        sb_q.push_back({8'h12, 1'b0});
        send_frame(8'h12, 1'b0, 1'b0);
        r_brx = 1'b0;
        repeat (2) @(negedge clk);
        r_brx = 1'b1;
        repeat (2 * N) @(negedge clk);
        sb_q.push_back({8'h77, 1'b0});
        send_frame(8'h77, 1'b0, 1'b0);
        wait_sb(FRAME, "directed_rx_timeout");
        last_vis = {8'h77, 1'b0};

        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0);
            fe = ($urandom_range(0, 4) == 0);
            // A repeat of the visible value would not show up as a change.
            if (!fe && {d, pb} == last_vis) d = d + 8'd1;
            if (!fe) begin
                sb_q.push_back({d, pb});
                last_vis = {d, pb};
            end
            send_frame(d, pb, fe);
        end
        wait_sb(FRAME, "random_rx_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
